alu_ext: RTL and testbench
==========================

ALU_EXT -- requirements
Module: alu_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of operands, result and bus.
REQ-002 SHALL have parameter SHW, default 3, width of shift-amount field (log2 WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 dbus  inout  WIDTH  shared data bus; driven only while su=1, else high-Z.
REQ-006 su  input  1  bus output enable for the result register.
REQ-007 start  input  1  one-cycle request to begin the operation selected by op.
REQ-008 op  input  3  operation code: ADD, SUB, AND, OR, XOR, CMP, SHL, SHR.
REQ-009 areg  input  WIDTH  operand A, signed two's complement.
REQ-010 breg  input  WIDTH  operand B, signed; low SHW bits give the shift amount for SHL/SHR.
REQ-011 busy  output  1  high while a multi-cycle shift is in progress.
REQ-012 done  output  1  one-cycle pulse when the result/flags become valid.
REQ-013 flags  output  4  registered {N, Z, C, V}.

Function
REQ-014 The block SHALL be an FSM with states IDLE, SHIFT, DONE.
REQ-015 In IDLE, start with ADD/SUB/AND/OR/XOR SHALL write result and flags at that edge, then go to DONE; done=1 for the following cycle.
REQ-016 ADD SHALL compute A+B mod 2^WIDTH; C = carry out; V = signed overflow.
REQ-017 SUB SHALL compute A-B mod 2^WIDTH; C = no-borrow (1 when A>=B unsigned); V = signed overflow.
REQ-018 AND/OR/XOR SHALL clear C and V.
REQ-019 CMP SHALL update flags as SUB without changing the result register.
REQ-020 N SHALL be result MSB and Z SHALL be 1 iff the result is all zeros (for CMP, of the A-B difference).
REQ-021 SHL/SHR SHALL load A into the result register, load shift count = B[SHW-1:0], and enter SHIFT; count 0 SHALL go directly to DONE.
REQ-022 In SHIFT each cycle SHALL shift the result one bit (SHL: zero fill; SHR: arithmetic, sign fill), decrement the count, set C to the bit shifted out, and leave SHIFT when count reaches 0; latency = count+1 cycles from start to done.
REQ-023 busy SHALL be 1 exactly in SHIFT; V SHALL be 0 after shifts.
REQ-024 start while busy=1 SHALL be ignored; start in DONE SHALL be accepted as in IDLE.
REQ-025 DONE SHALL last one cycle then return to IDLE unless a new start is accepted.
REQ-026 dbus SHALL present the result register whenever su=1, including mid-shift (intermediate value), independent of FSM state.
REQ-027 Result and flags SHALL hold their values between operations.

Reset
REQ-028 clr=1 at a rising edge SHALL set state IDLE, result 0, flags 0000, count 0, busy 0, done 0; clr SHALL dominate start.
REQ-029 clr asserted mid-shift SHALL abort the shift with no done pulse.
REQ-030 dbus drive SHALL depend only on su, so su=1 during reset SHALL drive 0.

Structure
REQ-031 op encodings (ADD=0 … SHR=7), state encodings and flag bit indices SHALL live in shared package alu_pkg.
REQ-032 Combinational add/sub/logic and flag generation SHALL be sub-module alu_core; the FSM, shifter, registers and tri-state stay in alu_ext.

Verification
REQ-033 WIDTH=8: A=0x7F, B=0x01, ADD -> result 0x80, flags N=1 Z=0 C=0 V=1, done one cycle after start.
REQ-034 A=0x05, B=0x05, SUB then CMP with A=0x03 -> result 0x00 Z=1 C=1; CMP: result stays 0x00, flags N=1 Z=0 C=0 V=0.
REQ-035 A=0x81, B=3, SHR -> busy 3 cycles, done at cycle 4, result 0xF0, C=0; start pulses during busy ignored.
REQ-036 A=0x81, B=1, SHL -> result 0x02, C=1, latency 2; B=0 SHL -> result 0x81, latency 1.
REQ-037 clr asserted during SHIFT -> next cycle result 0, flags 0, busy 0, no done.
REQ-038 su toggled -> dbus high-Z when su=0, result value when su=1; repeat with WIDTH=16.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the extended ALU: op codes, FSM states, flag layout.
package alu_pkg;

    // Operation codes, in the order the op input encodes them.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_CMP = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Flag bit indices within the 4-bit flags word {N, Z, C, V}.
    localparam int unsigned FLAG_N  = 3;
    localparam int unsigned FLAG_Z  = 2;
    localparam int unsigned FLAG_C  = 1;
    localparam int unsigned FLAG_V  = 0;
    localparam int unsigned FLAGS_W = 4;

    // Packed flags word; field order matches the indices above.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational arithmetic/logic datapath and flag generation.
// Ports:
//   op_i     operation code (shift codes produce zero; handled by the caller)
//   a_i/b_i  operands, two's complement
//   res_c    combinational result
//   flags_c  combinational {N, Z, C, V} for that result
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_c,
    output flags_t           flags_c
);

    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic           c_bit;
    logic           v_bit;

    // Subtraction as A + ~B + 1 so the carry out is the no-borrow flag.
    always_comb begin
        add_w = {1'b0, a_i} + {1'b0, b_i};
        sub_w = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
        res_c = '0;
        c_bit = 1'b0;
        v_bit = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_c = add_w[WIDTH-1:0];
                c_bit = add_w[WIDTH];
                v_bit = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                        (add_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res_c = sub_w[WIDTH-1:0];
                c_bit = sub_w[WIDTH];
                v_bit = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                        (sub_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  res_c = a_i & b_i;
            OP_OR:   res_c = a_i | b_i;
            OP_XOR:  res_c = a_i ^ b_i;
            default: res_c = '0;
        endcase
        flags_c.n = res_c[WIDTH-1];
        flags_c.z = (res_c == '0);
        flags_c.c = c_bit;
        flags_c.v = v_bit;
    end

endmodule : alu_core

// File: rtl/alu_ext.sv
// Extended ALU: single-cycle add/sub/logic/compare, multi-cycle bit-serial
// shifts, registered result and flags, tri-state result bus.
// Ports:
//   clk, clr      clock, synchronous active-high reset
//   dbus          result bus, driven while su=1, high-Z otherwise
//   su            bus output enable
//   start, op     one-cycle operation request and its code
//   areg, breg    operands (breg low SHW bits = shift count)
//   busy          high while a shift is in progress
//   done          one-cycle pulse when result/flags are valid
//   flags         registered {N, Z, C, V}
module alu_ext
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
) (
    input  logic               clk,
    input  logic               clr,
    inout  wire  [WIDTH-1:0]   dbus,
    input  logic               su,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   areg,
    input  logic [WIDTH-1:0]   breg,
    output logic               busy,
    output logic               done,
    output logic [FLAGS_W-1:0] flags
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             shl_q, shl_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] core_res_c;
    flags_t           core_flags_c;
    op_e              op_c;
    logic [WIDTH-1:0] shifted_c;
    logic             shout_c;

    assign op_c = op_e'(op);

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i    (op_c),
        .a_i     (areg),
        .b_i     (breg),
        .res_c   (core_res_c),
        .flags_c (core_flags_c)
    );

    // One shift step of the result register and the bit that falls out.
    always_comb begin
        if (shl_q) begin
            shifted_c = {result_q[WIDTH-2:0], 1'b0};
            shout_c   = result_q[WIDTH-1];
        end else begin
            shifted_c = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            shout_c   = result_q[0];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        count_d  = count_q;
        shl_d    = shl_q;
        case (state_q)
            ST_SHIFT: begin
                result_d = shifted_c;
                flags_d  = '{n: shifted_c[WIDTH-1], z: (shifted_c == '0),
                             c: shout_c, v: 1'b0};
                count_d  = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_DONE;
                    case (op_c)
                        OP_CMP: flags_d = core_flags_c;
                        OP_SHL, OP_SHR: begin
                            result_d = areg;
                            flags_d  = '{n: areg[WIDTH-1], z: (areg == '0),
                                         c: 1'b0, v: 1'b0};
                            count_d  = breg[SHW-1:0];
                            shl_d    = (op_c == OP_SHL);
                            if (breg[SHW-1:0] != '0) begin
                                state_d = ST_SHIFT;
                            end
                        end
                        default: begin
                            result_d = core_res_c;
                            flags_d  = core_flags_c;
                        end
                    endcase
                end
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            count_q  <= '0;
            shl_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            count_q  <= count_d;
            shl_q    <= shl_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign flags = flags_q;

    // Bus drive depends on su alone, so intermediate shift values are visible.
    assign dbus = su ? result_q : {WIDTH{1'bz}};

endmodule : alu_ext

// File: tb/tb_alu_ext.sv
module tb_alu_ext;

    logic              clk;
    logic              clr;
    logic [1:0]        start_s;
    logic [1:0]        su_s;
    logic [2:0]        op_s  [2];
    logic [15:0]       a_s   [2];
    logic [15:0]       b_s   [2];
    logic [15:0]       tbv   [2];
    wire  [7:0]        dbus8;
    wire  [15:0]       dbus16;
    logic              busy8, done8, busy16, done16;
    logic [3:0]        flags8, flags16;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Behavioural model state, index 0 = 8-bit instance, 1 = 16-bit.
    int m_res[2], m_flags[2], m_busy[2], m_done[2];
    int m_a[2], m_n[2], m_k[2], m_shl[2];

    alu_ext #(.WIDTH(8), .SHW(3)) dut8 (
        .clk(clk), .clr(clr), .dbus(dbus8), .su(su_s[0]), .start(start_s[0]),
        .op(op_s[0]), .areg(a_s[0][7:0]), .breg(b_s[0][7:0]),
        .busy(busy8), .done(done8), .flags(flags8)
    );

    alu_ext #(.WIDTH(16), .SHW(4)) dut16 (
        .clk(clk), .clr(clr), .dbus(dbus16), .su(su_s[1]), .start(start_s[1]),
        .op(op_s[1]), .areg(a_s[1]), .breg(b_s[1]),
        .busy(busy16), .done(done16), .flags(flags16)
    );

    // Bench drives the bus whenever the DUT is meant to be released.
    assign dbus8  = su_s[0] ? 8'bz  : tbv[0][7:0];
    assign dbus16 = su_s[1] ? 16'bz : tbv[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic int sval(int x, int w);
        return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    endfunction

    function automatic int mkf(int res, int w, int c, int v);
        return (((res >> (w - 1)) & 1) << 3) | ((res == 0) ? 4 : 0) | (c << 1) | v;
    endfunction

    // Result after k shift steps of a, computed in one go.
    function automatic int shres(int a, int w, int k, int shl);
        int mask = (1 << w) - 1;
        if (shl != 0) return (a << k) & mask;
        return (sval(a, w) >>> k) & mask;
    endfunction

    function automatic int shc(int a, int w, int k, int shl);
        if (k == 0) return 0;
        if (shl != 0) return (a >> (w - k)) & 1;
        return (a >> (k - 1)) & 1;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluates accepted requests arithmetically.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int w, mask, a, b, sa, sb, r, c, v;
            w    = wid(d);
            mask = (1 << w) - 1;
            a    = 32'(a_s[d]) & mask;
            b    = 32'(b_s[d]) & mask;
            sa   = sval(a, w);
            sb   = sval(b, w);
            if (clr) begin
                m_res[d] = 0; m_flags[d] = 0; m_busy[d] = 0; m_done[d] = 0;
            end else if (start_s[d] && m_busy[d] == 0) begin
                m_done[d] = 1;
                m_busy[d] = 0;
                case (int'(op_s[d]))
                    0: begin
                        r = a + b;
                        c = (r >> w) & 1;
                        v = ((sa + sb) != sval(r & mask, w)) ? 1 : 0;
                        m_res[d] = r & mask;
                        m_flags[d] = mkf(m_res[d], w, c, v);
                    end
                    1, 5: begin
                        r = (a - b) & mask;
                        c = (a >= b) ? 1 : 0;
                        v = ((sa - sb) != sval(r, w)) ? 1 : 0;
                        m_flags[d] = mkf(r, w, c, v);
                        if (op_s[d] == 3'd1) m_res[d] = r;
                    end
                    2: begin m_res[d] = a & b; m_flags[d] = mkf(m_res[d], w, 0, 0); end
                    3: begin m_res[d] = a | b; m_flags[d] = mkf(m_res[d], w, 0, 0); end
                    4: begin m_res[d] = a ^ b; m_flags[d] = mkf(m_res[d], w, 0, 0); end
                    default: begin
                        m_a[d]   = a;
                        m_n[d]   = b & (w - 1);
                        m_k[d]   = 0;
                        m_shl[d] = (op_s[d] == 3'd6) ? 1 : 0;
                        m_res[d] = a;
                        m_flags[d] = mkf(a, w, 0, 0);
                        if (m_n[d] != 0) begin
                            m_busy[d] = 1;
                            m_done[d] = 0;
                        end
                    end
                endcase
            end else if (m_busy[d] != 0) begin
                m_k[d]++;
                m_res[d]   = shres(m_a[d], w, m_k[d], m_shl[d]);
                m_flags[d] = mkf(m_res[d], w, shc(m_a[d], w, m_k[d], m_shl[d]), 0);
                if (m_k[d] == m_n[d]) begin
                    m_busy[d] = 0;
                    m_done[d] = 1;
                end
            end else begin
                m_done[d] = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("d8 busy",   32'(busy8),  m_busy[0]);
            check("d8 done",   32'(done8),  m_done[0]);
            check("d8 flags",  32'(flags8), m_flags[0]);
            check("d8 dbus",   32'(dbus8),  su_s[0] ? m_res[0] : 32'(tbv[0][7:0]));
            check("d16 busy",  32'(busy16), m_busy[1]);
            check("d16 done",  32'(done16), m_done[1]);
            check("d16 flags", 32'(flags16), m_flags[1]);
            check("d16 dbus",  32'(dbus16), su_s[1] ? m_res[1] : 32'(tbv[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue(int d, int op, int a, int b);
        start_s[d] = 1'b1;
        op_s[d]    = 3'(op);
        a_s[d]     = 16'(a);
        b_s[d]     = 16'(b);
        tick();
        start_s[d] = 1'b0;
        sample();
    endtask

    initial begin
        clr     = 1'b1;
        start_s = '0;
        su_s    = 2'b11;
        for (int d = 0; d < 2; d++) begin
            op_s[d] = '0; a_s[d] = '0; b_s[d] = '0; tbv[d] = '0;
        end
        tick();
        tick();
        sample();
        check("reset flags", 32'(flags8), 0);
        check("reset busy",  32'(busy8), 0);
        check("reset done",  32'(done8), 0);
        check("reset dbus",  32'(dbus8), 0);
        chk_en = 1;
        tick();
        clr = 1'b0;

        // ADD overflow into the sign bit.
        issue(0, 0, 'h7F, 'h01);
        check("add done",  32'(done8), 1);
        check("add res",   32'(dbus8), 'h80);
        check("add flags", 32'(flags8), 'b1001);
        tick();
        sample();
        check("add done pulse", 32'(done8), 0);

        // SUB to zero, then CMP leaves result untouched.
        issue(0, 1, 'h05, 'h05);
        check("sub res",   32'(dbus8), 'h00);
        check("sub flags", 32'(flags8), 'b0110);
        issue(0, 5, 'h03, 'h05);
        check("cmp res",   32'(dbus8), 'h00);
        check("cmp flags", 32'(flags8), 'b1000);
        check("cmp done",  32'(done8), 1);

        // SHR by 3 with start pulses ignored while busy.
        start_s[0] = 1'b1; op_s[0] = 3'd7; a_s[0] = 16'h0081; b_s[0] = 16'd3;
        tick();
        op_s[0] = 3'd0; a_s[0] = '0; b_s[0] = '0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("shr busy", 32'(busy8), (i < 3) ? 1 : 0);
            check("shr done", 32'(done8), (i == 3) ? 1 : 0);
            if (i < 3) begin
                tick();
                if (i == 2) start_s[0] = 1'b0;
            end
        end
        check("shr res",   32'(dbus8), 'hF0);
        check("shr flags", 32'(flags8), 'b1000);

        // SHL by 1 and by 0.
        tick();
        start_s[0] = 1'b1; op_s[0] = 3'd6; a_s[0] = 16'h0081; b_s[0] = 16'd1;
        tick();
        start_s[0] = 1'b0;
        sample();
        check("shl1 busy", 32'(busy8), 1);
        check("shl1 early done", 32'(done8), 0);
        tick();
        sample();
        check("shl1 done",  32'(done8), 1);
        check("shl1 res",   32'(dbus8), 'h02);
        check("shl1 flags", 32'(flags8), 'b0010);
        issue(0, 6, 'h81, 'h00);
        check("shl0 done", 32'(done8), 1);
        check("shl0 busy", 32'(busy8), 0);
        check("shl0 res",  32'(dbus8), 'h81);

        // Clear during a shift aborts it without a done pulse.
        tick();
        start_s[0] = 1'b1; op_s[0] = 3'd7; a_s[0] = 16'h0081; b_s[0] = 16'd7;
        tick();
        start_s[0] = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        sample();
        check("clr busy",  32'(busy8), 0);
        check("clr done",  32'(done8), 0);
        check("clr flags", 32'(flags8), 0);
        check("clr res",   32'(dbus8), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            sample();
            check("clr no done", 32'(done8), 0);
        end

        // Bus release and drive, 8-bit then 16-bit.
        issue(0, 2, 'h3C, 'hF0);
        check("and res", 32'(dbus8), 'h30);
        tick();
        su_s[0] = 1'b0; tbv[0] = 16'h005A;
        sample();
        check("su0 hiz8", 32'(dbus8), 'h5A);
        tick();
        su_s[0] = 1'b1;
        sample();
        check("su1 drive8", 32'(dbus8), 'h30);
        issue(1, 0, 'h7FFF, 'h0001);
        check("add16 res",   32'(dbus16), 'h8000);
        check("add16 flags", 32'(flags16), 'b1001);
        tick();
        su_s[1] = 1'b0; tbv[1] = 16'h1234;
        sample();
        check("su0 hiz16", 32'(dbus16), 'h1234);
        tick();
        su_s[1] = 1'b1;
        sample();
        check("su1 drive16", 32'(dbus16), 'h8000);

        // Randomised traffic on both instances.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            clr = ($urandom_range(199) == 0);
            for (int d = 0; d < 2; d++) begin
                start_s[d] = ($urandom_range(2) == 0);
                op_s[d]    = 3'($urandom_range(7));
                a_s[d]     = 16'($urandom);
                b_s[d]     = 16'($urandom);
                su_s[d]    = ($urandom_range(3) != 0);
                tbv[d]     = 16'($urandom);
            end
        end
        tick();
        clr = 1'b0;
        start_s = '0;
        su_s = 2'b11;
        repeat (20) tick();
        sample();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_ext
